// File: rtl/ascon_state_loader.sv
// ============================================================================
// ascon_state_loader : byte-serial Ascon state assembler with a valid/ready handoff
// Optional: ASCON_LOADER_IV_EN (lane 0 holds the fixed IV)       Rev 1.0
// ============================================================================
`default_nettype none

module ascon_state_loader #(
  parameter int LANE_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [LANE_W-1:0] S_0_out,
  output logic [LANE_W-1:0] S_1_out,
  output logic [LANE_W-1:0] S_2_out,
  output logic [LANE_W-1:0] S_3_out,
  output logic [LANE_W-1:0] S_4_out,
  output logic [4:0]        byte_cnt
);

  localparam int BPL       = LANE_W / 8;
  localparam int NUM_BYTES = 5 * BPL;
`ifdef ASCON_LOADER_IV_EN
  localparam int FIRST_LANE = 1;
`else
  localparam int FIRST_LANE = 0;
`endif
  localparam int         FILL_BYTES = NUM_BYTES - FIRST_LANE * BPL;
  localparam logic [4:0] LAST_IDX   = 5'(FILL_BYTES - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_d;
  logic        accept;
  logic        handoff;
  logic [LANE_W-1:0] lanes [5];

  assign in_ready = (state_q == FILL) && !clear;
  assign st_valid = (state_q == HOLD);
  assign accept   = in_valid && in_ready;
  assign handoff  = st_valid && st_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = byte_cnt;
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (byte_cnt == LAST_IDX) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = byte_cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (st_ready) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      byte_cnt <= '0;
    end else begin
      state_q  <= state_d;
      byte_cnt <= cnt_d;
    end
  end

  // Byte k of the fill lands big-endian in lane FIRST_LANE + k/BPL; the
  // slot is picked by decoding byte_cnt against each slot's fixed index.
  generate
    for (genvar l = FIRST_LANE; l < 5; l++) begin : g_lane
      localparam int BASE = (l - FIRST_LANE) * BPL;
      logic [LANE_W-1:0] lane_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= '0;
        end else if (accept) begin
          for (int b = 0; b < BPL; b++) begin
            if (byte_cnt == 5'(BASE + b)) lane_q[LANE_W-1-8*b -: 8] <= in_data;
          end
        end
      end

      assign lanes[l] = lane_q;
    end
  endgenerate

`ifdef ASCON_LOADER_IV_EN
  generate
    if (FIRST_LANE == 1) begin : g_iv
      localparam logic [LANE_W-1:0] IV = LANE_W'(48'h80400c060000);
      logic [LANE_W-1:0] iv_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          iv_q <= IV;
        end else if (clear || handoff) begin
          iv_q <= IV;
        end
      end

      assign lanes[0] = iv_q;
    end
  endgenerate
`endif

  assign S_0_out = lanes[0];
  assign S_1_out = lanes[1];
  assign S_2_out = lanes[2];
  assign S_3_out = lanes[3];
  assign S_4_out = lanes[4];

endmodule

`default_nettype wire

// File: tb/tb_ascon_state_loader.sv
// ============================================================================
// tb_ascon_state_loader : directed scoreboard bench for ascon_state_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ascon_state_loader;

  localparam int LANE_W = 48;
  localparam int BPL    = LANE_W / 8;
  localparam logic [LANE_W-1:0] IV = 48'h80400c060000;
`ifdef ASCON_LOADER_IV_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif
  localparam int NB = (5 - FL) * BPL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              clear = 1'b0;
  logic              st_valid;
  logic              st_ready = 1'b0;
  logic [LANE_W-1:0] S_0_out, S_1_out, S_2_out, S_3_out, S_4_out;
  logic [4:0]        byte_cnt;

  ascon_state_loader #(.LANE_W(LANE_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .S_0_out  (S_0_out),
    .S_1_out  (S_1_out),
    .S_2_out  (S_2_out),
    .S_3_out  (S_3_out),
    .S_4_out  (S_4_out),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [LANE_W-1:0] model [5];
  logic [LANE_W-1:0] sb_q [$];
  logic [LANE_W-1:0] dut_l [5];

  assign dut_l[0] = S_0_out;
  assign dut_l[1] = S_1_out;
  assign dut_l[2] = S_2_out;
  assign dut_l[3] = S_3_out;
  assign dut_l[4] = S_4_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks sit at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) model[i] = '0;
    if (FL == 1) model[0] = IV;
  endtask

  task automatic load(input int base, input int count, input bit bubbles);
    for (int k = 0; k < count; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + k);
      #4;
      chk("in_ready_fill", 64'(in_ready), 64'd1);
      if (k % 7 == 0) chk("byte_cnt_fill", 64'(byte_cnt), 64'(k));
      model[FL + k / BPL][LANE_W-1-8*(k % BPL) -: 8] = 8'(base + k);
      tick();
      if (bubbles) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        #4;
        if (k % 5 == 0 || k == NB - 1)
          chk("byte_cnt_bubble", 64'(byte_cnt), 64'((k + 1) % NB));
        tick();
      end
    end
    in_valid = 1'b0;
    if (count == NB) begin
      for (int i = 0; i < 5; i++) sb_q.push_back(model[i]);
    end
  endtask

  task automatic check_hold();
    logic [LANE_W-1:0] e;
    #4;
    chk("st_valid_hold", 64'(st_valid), 64'd1);
    chk("in_ready_hold", 64'(in_ready), 64'd0);
    chk("byte_cnt_hold", 64'(byte_cnt), 64'd0);
    if (sb_q.size() < 5) begin
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        e = sb_q.pop_front();
        chk($sformatf("lane%0d", i), 64'(dut_l[i]), 64'(e));
      end
    end
    tick();
  endtask

  task automatic handshake();
    st_ready = 1'b1;
    #4;
    chk("st_valid_hs", 64'(st_valid), 64'd1);
    tick();
    st_ready = 1'b0;
    #4;
    chk("st_valid_after_hs", 64'(st_valid), 64'd0);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    chk("rst_st_valid", 64'(st_valid), 64'd0);
    chk("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_S_0", 64'(S_0_out), (FL == 1) ? 64'(IV) : 64'd0);
    chk("rst_S_4", 64'(S_4_out), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full back-to-back load
    load(8'h00, NB, 1'b0);
`ifdef ASCON_LOADER_IV_EN
    #4;
    chk("iv_S_0", 64'(S_0_out), 64'h80400c060000);
    chk("iv_S_1", 64'(S_1_out), 64'h000102030405);
    chk("iv_S_4", 64'(S_4_out), 64'h121314151617);
    #1;
    tick();
`else
    #4;
    chk("full_S_0", 64'(S_0_out), 64'h000102030405);
    chk("full_S_2", 64'(S_2_out), 64'h0c0d0e0f1011);
    chk("full_S_4", 64'(S_4_out), 64'h18191a1b1c1d);
    #1;
    tick();
`endif
    check_hold();

    // Backpressure with a byte offered throughout
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("bp_st_valid", 64'(st_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_S_1", 64'(S_1_out), 64'(model[1]));
      chk("bp_S_4", 64'(S_4_out), 64'(model[4]));
      tick();
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_byte_cnt", 64'(byte_cnt), 64'd0);

    // Bubbled load of the same data
    load(8'h00, NB, 1'b1);
    check_hold();
    handshake();

    // Clear mid-fill, offering 0xAA in the clear cycle
    load(8'h40, 10, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #4;
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    #4;
    chk("clr_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("clr_st_valid", 64'(st_valid), 64'd0);
    chk("clr_in_ready_after", 64'(in_ready), 64'd1);
    chk("clr_lane_a", 64'(dut_l[FL]), 64'(model[FL]));
    chk("clr_lane_b", 64'(dut_l[FL + 1]), 64'(model[FL + 1]));
    tick();
    load(8'hF0, NB, 1'b0);
    #4;
    chk("clr_reload_first", 64'(dut_l[FL]), 64'hf0f1f2f3f4f5);
    #1;
    tick();
    check_hold();

    // Clear coinciding with the handoff
    clear    = 1'b1;
    st_ready = 1'b1;
    tick();
    clear    = 1'b0;
    st_ready = 1'b0;
    #4;
    chk("clrhs_st_valid", 64'(st_valid), 64'd0);
    chk("clrhs_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("clrhs_in_ready", 64'(in_ready), 64'd1);
    chk("clrhs_S_0", 64'(S_0_out), 64'(model[0]));
    tick();

    // Asynchronous reset while holding a state
    load(8'h80, NB, 1'b0);
    check_hold();
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_st_valid", 64'(st_valid), 64'd0);
    chk("arst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("arst_S_0", 64'(S_0_out), 64'(model[0]));
    chk("arst_S_3", 64'(S_3_out), 64'd0);
    chk("arst_S_4", 64'(S_4_out), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    #4;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ascon_state_loader.md
# ascon_state_loader

Byte-serial state loader that sits directly upstream of the Ascon permutation core. Accepts the initial permutation state one byte per cycle over a valid/ready stream and assembles it into five 48-bit lanes. Presents the completed state to the permutation core through a valid/ready handoff. It replaces the hard-coded initial-state load in the core.

## Interface

Parameters:
- `LANE_W`, default 48: lane width in bits; must be a multiple of 8.
- `NUM_BYTES`, derived as 5*LANE_W/8 (30): bytes per full state.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_data`, in, 8: state byte.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `clear`, in, 1: synchronous abort of the current fill or hold.
- `st_valid`, out, 1: full state present on the lane outputs.
- `st_ready`, in, 1: permutation core takes the state.
- `S_0_out` … `S_4_out`, out, LANE_W each: assembled lanes.
- `byte_cnt`, out, 5: bytes accepted in the current fill.

## Operation

- There are two states: FILL and HOLD. Reset enters FILL with `byte_cnt`=0.
- **FILL**
  - `in_ready` = !`clear`.
  - An accept occurs when `in_valid && in_ready`.
  - On accept, byte k (k = `byte_cnt`) is written to lane k/6, bits [LANE_W-1-8*(k%6) -: 8]. Ordering is big-endian: the first byte is the MSB of `S_0_out`.
  - Each accept increments `byte_cnt` by 1.
  - The accept of the last byte (k = last index) moves the block to HOLD and resets `byte_cnt` to 0.
- **HOLD**
  - `in_ready`=0 and `st_valid`=1.
  - Lanes are frozen.
  - On `st_valid && st_ready`, the block returns to FILL.
- Lanes keep their contents after a handoff. Each byte is overwritten as the next fill proceeds.
- **`clear`**
  - In any state: next state is FILL, `byte_cnt`=0, `st_valid`=0.
  - A byte offered in the same cycle is dropped, because `in_ready` is 0.
  - Lanes are not zeroed, except in the IV lane rule under Configuration.
- `clear` together with an `st` handshake: `clear` wins. The resulting state is identical (FILL, count 0).
- No arithmetic beyond the count increment. `byte_cnt` never exceeds NUM_BYTES-1 and never wraps.

## Timing

- **Reset values:**
  - `st_valid`=0.
  - `byte_cnt`=0.
  - All lanes 0, except `S_0_out` under Configuration.
  - `in_ready`=1 while `clear`=0.
- `in_ready` is combinational from the registered state and `clear`. `st_valid` is a registered state decode. There are no combinational paths from `st_ready` to `in_ready`.
- **Latency and throughput:**
  - The last byte is accepted at cycle N. `st_valid`=1 from cycle N+1.
  - The handshake at cycle M gives `in_ready`=1 at M+1.
  - Throughput is one byte per cycle. Bubbles on `in_valid` are allowed anywhere.
- Reset asserted mid-fill or mid-hold returns all registers to reset values immediately (asynchronous). `rst_n` deassertion is synchronised externally.

## Configuration

- **`ASCON_LOADER_IV_EN` defined:**
  - `S_0_out` is loaded with the constant IV 48'h80400c060000 at reset, on `clear`, and on each `st` handshake.
  - Only lanes 1–4 are filled from the stream. Each fill is 4*LANE_W/8 (24) bytes.
  - Byte k goes to lane 1 + k/6.
- **Not defined:** all five lanes are streamed (30 bytes), and `S_0_out` resets to 0.

## Test plan

- **Full load (macro off):** send bytes 0x00..0x1D back-to-back.
  - `st_valid` is 1 the cycle after the 30th accept.
  - `S_0_out`=48'h000102030405.
  - `S_2_out`=48'h0c0d0e0f1011.
  - `S_4_out`=48'h18191a1b1c1d.
- **Backpressure:** after a full load, hold `st_ready`=0 for 5 cycles with `in_valid`=1.
  - `st_valid` stays 1, `in_ready` stays 0, and lanes are unchanged.
  - Raising `st_ready` for 1 cycle drops `st_valid` and gives `in_ready`=1 on the next cycle.
- **Bubbles:** alternate `in_valid` 1/0 across 30 bytes.
  - Result is the same as the full-load case.
  - `byte_cnt` advances only on accepts.
- **Clear mid-fill:** pulse `clear` after 10 bytes, offering byte 0xAA in the same cycle.
  - 0xAA is not accepted and `byte_cnt`=0.
  - A subsequent 30-byte load of 0xF0..0x10D (low byte) produces `S_0_out`=48'hf0f1f2f3f4f5.
- **IV mode (macro on):** send 24 bytes 0x00..0x17.
  - `st_valid` is 1 after the 24th accept.
  - `S_0_out`=48'h80400c060000.
  - `S_1_out`=48'h000102030405.
  - `S_4_out`=48'h121314151617.
- **Reset in HOLD:** assert `rst_n`=0 while `st_valid`=1.
  - `st_valid`=0, `byte_cnt`=0, and lanes return to reset values without waiting for a clock edge.
